// File: rtl/clk_gate_seq.sv
// clk_gate_seq: serialises per-peripheral clock gate/ungate requests through an idle handshake.
// Latency: request change to first output update is 2 HCLK edges; one channel sequenced at a time.
// Backpressure: REQ waits on idle_ack_i; optional timeout (CLK_GATE_SEQ_TIMEOUT_EN) aborts and blocks the channel.
module clk_gate_seq #(
  parameter int NUM_PERIPH    = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_PERIPH-1:0] clk_gate_i,
  input  logic [NUM_PERIPH-1:0] idle_ack_i,
  input  logic                  timeout_clr_i,
  output logic [NUM_PERIPH-1:0] clk_en_o,
  output logic [NUM_PERIPH-1:0] idle_req_o,
  output logic                  busy_o,
  output logic [NUM_PERIPH-1:0] timeout_o
);

  localparam int IDX_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GATE,
    ST_UNGATE,
    ST_RELEASE
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
    , ST_ABORT
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, pick_idx;
  logic [7:0]              cnt_q;
  logic                    busy_q;
  logic [NUM_PERIPH-1:0]   req_q, clk_en_q, idle_req_q;
  logic [NUM_PERIPH-1:0]   nxt_clk_en, nxt_idle_req;
  logic [NUM_PERIPH-1:0]   pending;
  logic                    settle_done, ack_hit;

`ifdef CLK_GATE_SEQ_TIMEOUT_EN
  logic [NUM_PERIPH-1:0]   blocked_q, timeout_q, abort_mask;
  logic                    ack_expired;

  assign ack_expired = (cnt_q == 8'(ACK_TIMEOUT - 1));
  assign pending     = (req_q ^ clk_en_q) & ~blocked_q;
  assign timeout_o   = timeout_q;
`else
  logic [8:0]              unused_timeout_cfg;

  assign unused_timeout_cfg = {timeout_clr_i, 8'(ACK_TIMEOUT)};
  assign pending            = req_q ^ clk_en_q;
  assign timeout_o          = '0;
`endif

  assign settle_done = (cnt_q == 8'(SETTLE_CYCLES - 1));
  assign ack_hit     = idle_ack_i[idx_q];
  assign clk_en_o    = clk_en_q;
  assign idle_req_o  = idle_req_q;
  assign busy_o      = busy_q;

  // Lowest-index pending channel wins.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
      if (pending[i]) pick_idx = IDX_W'(i);
    end
  end

  // State, channel index, per-state cycle counter, busy flag and request sampling.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      req_q   <= '1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) idx_q <= pick_idx;
      cnt_q   <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
      busy_q  <= (state_d != ST_IDLE);
      req_q   <= clk_gate_i;
    end
  end

  // Next-state selection for the single in-flight sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|pending) state_d = clk_en_q[pick_idx] ? ST_REQ : ST_UNGATE;
      ST_REQ: begin
        if (ack_hit) state_d = ST_GATE;
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
        else if (ack_expired) state_d = ST_ABORT;
`endif
      end
      ST_GATE:    if (settle_done) state_d = ST_IDLE;
      ST_UNGATE:  if (settle_done) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
      ST_ABORT:   state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered per-channel outputs, driven by the current transition.
  always_comb begin
    nxt_clk_en   = clk_en_q;
    nxt_idle_req = idle_req_q;
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
    abort_mask   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          if (clk_en_q[pick_idx]) nxt_idle_req[pick_idx] = 1'b1;
          else                    nxt_clk_en[pick_idx]   = 1'b1;
        end
      end
      ST_REQ:     if (ack_hit) nxt_clk_en[idx_q] = 1'b0;
      ST_UNGATE:  if (settle_done) nxt_idle_req[idx_q] = 1'b0;
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
      ST_ABORT: begin
        nxt_idle_req[idx_q] = 1'b0;
        abort_mask[idx_q]   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Output registers; a clear pulse never wipes a flag being raised in the same cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clk_en_q   <= '1;
      idle_req_q <= '0;
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
      blocked_q  <= '0;
      timeout_q  <= '0;
`endif
    end else begin
      clk_en_q   <= nxt_clk_en;
      idle_req_q <= nxt_idle_req;
`ifdef CLK_GATE_SEQ_TIMEOUT_EN
      blocked_q  <= (blocked_q & (req_q ^ clk_en_q)) | abort_mask;
      timeout_q  <= timeout_clr_i ? abort_mask : (timeout_q | abort_mask);
`endif
    end
  end

endmodule

// File: doc/clk_gate_seq.md
# clk_gate_seq

Handshaking clock-gate sequencer sitting directly downstream of the APB SoC control register block. It consumes the 32-bit clock-gate request vector from that block's clk_gate output and turns each bit change into a safe, one-at-a-time gating sequence for the matching peripheral. Clocks are gated only after the peripheral acknowledges idle, and an optional timeout aborts hung handshakes. It drives the per-peripheral clock-enable bits into the clock-gating cells and the idle-request lines into the peripherals.

## Interface
- NUM_PERIPH, 32, number of gated channels (1..32)
- SETTLE_CYCLES, 2, cycles held after each clk_en edge before the next action (1..15)
- ACK_TIMEOUT, 255, max cycles to wait for idle_ack (1..255; used only with timeout feature)

- HCLK  in  1  free-running clock
- HRESETn  in  1  reset, asynchronous, active-low
- clk_gate_i  in  NUM_PERIPH  requested clock enable per channel (1 = clock on)
- idle_ack_i  in  NUM_PERIPH  peripheral reports quiescent, HCLK-synchronous
- timeout_clr_i  in  1  single-cycle pulse, clears timeout_o
- clk_en_o  out  NUM_PERIPH  enable to clock-gating cell per channel
- idle_req_o  out  NUM_PERIPH  request peripheral to go/stay quiescent
- busy_o  out  1  sequence in progress (state != IDLE)
- timeout_o  out  NUM_PERIPH  sticky per-channel handshake timeout flag

## Operation
- Reset values: clk_en_o all 1, idle_req_o 0, busy_o 0, timeout_o 0; req_q all 1, blocked_q 0, state IDLE.
- req_q registers clk_gate_i every cycle. pending = (req_q ^ clk_en_q) & ~blocked_q.
- IDLE: if pending != 0, latch idx = lowest set bit of pending; go REQ if clk_en_q[idx]=1 (turn-off), else UNGATE (turn-on).
- REQ: idle_req_o[idx]=1, cnt increments each cycle. idle_ack_i[idx]=1 -> GATE. With timeout: cnt reaches ACK_TIMEOUT without ack -> ABORT.
- GATE: clk_en_o[idx]=0 on entry; hold SETTLE_CYCLES cycles -> IDLE. idle_req_o[idx] stays 1 while gated.
- UNGATE: clk_en_o[idx]=1 on entry; hold SETTLE_CYCLES cycles -> RELEASE.
- RELEASE: idle_req_o[idx]=0 for one cycle -> IDLE.
- ABORT: idle_req_o[idx]=0, timeout_o[idx]=1, blocked_q[idx]=1, clk_en unchanged -> IDLE.
- blocked_q[i] clears when req_q[i]==clk_en_q[i] (request withdrawn); a new off request then retries.
- Request change for idx mid-sequence: current sequence completes; the reverse sequence starts on the next IDLE evaluation.
- Simultaneous changes on several bits: serviced lowest index first, one sequence at a time.
- idle_ack_i ignored outside REQ and for channels other than idx.
- timeout_clr_i has priority under simultaneous set: the flag set in ABORT that cycle survives; all other bits clear.
- HRESETn low at any time: all state and outputs return to reset values asynchronously; the sequence in flight is dropped.

## Timing
- clk_gate_i change before edge E -> req_q at E -> state change and idle_req_o/clk_en_o update at E+1.
- Turn-off with ack already high: idle_req_o rises at E+1, clk_en_o falls at E+2, IDLE at E+2+SETTLE_CYCLES.
- Turn-on: clk_en_o rises at E+1, idle_req_o falls at E+1+SETTLE_CYCLES, IDLE one cycle later.
- Timeout: REQ entered at edge T, ABORT at T+ACK_TIMEOUT, flag visible at T+ACK_TIMEOUT+1.
- busy_o registered, high exactly while state != IDLE.

## Configuration
- CLK_GATE_SEQ_TIMEOUT_EN defined: cnt, ABORT state, blocked_q, and timeout_o logic present as described.
- Undefined: REQ waits indefinitely for idle_ack_i, no ABORT state, blocked_q removed, timeout_o tied to 0, timeout_clr_i ignored.

## Test plan
- Reset, clk_gate_i=32'hFFFF_FFFF -> clk_en_o=32'hFFFF_FFFF, idle_req_o=0, busy_o=0, no activity for 20 cycles.
- Clear bit 3, ack bit 3 after 5 cycles -> idle_req_o[3]=1, clk_en_o[3]=0 one cycle after ack, busy_o low SETTLE_CYCLES later.
- Set bit 3 again -> clk_en_o[3]=1, idle_req_o[3]=0 after SETTLE_CYCLES, clk_en_o=32'hFFFF_FFFF.
- Clear bits 7 and 2 together, acks tied high -> bit 2 gated before bit 7, never two idle_req rising in one sequence.
- Timeout (macro on, ACK_TIMEOUT=10): clear bit 5, no ack -> after 10 cycles timeout_o=32'h20, clk_en_o[5]=1, no retry; restore bit 5, clear it again with ack -> gated; pulse timeout_clr_i -> timeout_o=0.
- Assert HRESETn low while in GATE for bit 1 -> clk_en_o=32'hFFFF_FFFF, idle_req_o=0, busy_o=0 immediately.
